// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits with a blanking gap and frame-synchronous data commit.
// Define FND_LZB_EN to enable leading-zero blanking (digits above the top nonzero nibble stay dark).
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [3:0]              fnd_num,
  output logic [NUM_DIGITS-1:0]   fnd_com
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK    = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0]          div_cnt, div_nx;
  logic [IDX_W-1:0]          digit_idx, idx_nx;
  logic [4*NUM_DIGITS-1:0]   shadow, shadow_nx;
  logic [4*NUM_DIGITS-1:0]   disp, disp_nx;
  logic                      pending_nx;
  logic                      wrap_slot, boundary, commit;
  logic [3:0]                fnd_num_nx;
  logic [NUM_DIGITS-1:0]     fnd_com_nx;
  logic                      lit;
`ifdef FND_LZB_EN
  logic [IDX_W-1:0]          top;
`endif

  // Counters, shadow/display data and pending flag; disabled scan commits every cycle.
  always_comb begin
    wrap_slot  = (div_cnt == CNT_LAST);
    boundary   = enable && wrap_slot && (digit_idx == IDX_LAST);
    commit     = boundary || !enable;
    div_nx     = div_cnt;
    idx_nx     = digit_idx;
    shadow_nx  = shadow;
    disp_nx    = disp;
    pending_nx = pending;

    if (!enable) begin
      div_nx = '0;
      idx_nx = '0;
    end else if (wrap_slot) begin
      div_nx = '0;
      idx_nx = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      div_nx = div_cnt + 1'b1;
    end

    if (load)
      shadow_nx = data_in;

    if (commit && load) begin
      disp_nx    = data_in;
      pending_nx = 1'b0;
    end else if (commit && pending) begin
      disp_nx    = shadow;
      pending_nx = 1'b0;
    end else if (load) begin
      pending_nx = 1'b1;
    end
  end

  // Outputs are derived from next-state values so the registered outputs line up with the counters.
  always_comb begin
    fnd_num_nx = '0;
    fnd_com_nx = '1;
    lit        = 1'b1;
`ifdef FND_LZB_EN
    top = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (disp_nx[4*i +: 4] != 4'h0)
        top = IDX_W'(i);
    lit = (idx_nx <= top);
`endif
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nx == IDX_W'(i)) begin
        fnd_num_nx = disp_nx[4*i +: 4];
        if (enable && lit && (div_nx >= BLANK))
          fnd_com_nx[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      digit_idx  <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      fnd_num    <= '0;
      fnd_com    <= '1;
    end else begin
      div_cnt    <= div_nx;
      digit_idx  <= idx_nx;
      shadow     <= shadow_nx;
      disp       <= disp_nx;
      pending    <= pending_nx;
      frame_tick <= boundary;
      fnd_num    <= fnd_num_nx;
      fnd_com    <= fnd_com_nx;
    end
  end

endmodule
